// File: rtl/alu_logic_collector_if.sv
// Bus bundle between the issuer/consumer and the logic-result collector.
interface alu_logic_collector_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] xor_output;
    logic [WIDTH-1:0] xnor_output;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] op_count;

    // Collector side
    modport slave (
        input  in_valid, in_op, xor_output, xnor_output, out_ready,
        output in_ready, out_valid, out_result, out_flags, op_count
    );

    // Issuer / consumer side
    modport master (
        output in_valid, in_op, xor_output, xnor_output, out_ready,
        input  in_ready, out_valid, out_result, out_flags, op_count
    );
endinterface

// File: rtl/alu_logic_collector.sv
// Collects XOR/XNOR unit results one cycle after issue, attaches status flags and
// buffers them in a credit-protected FIFO with a ready/valid output.
module alu_logic_collector #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    alu_logic_collector_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned ENT_W = WIDTH + 4;

    logic             r_pend_v;
    logic [1:0]       r_pend_op;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_op_count;
    logic [ENT_W-1:0] r_mem [DEPTH];

    logic             w_in_ready;
    logic             w_issue;
    logic             w_capture;
    logic             w_pop;
    logic             w_out_valid;
    logic [OCC_W-1:0] w_credit;
    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic [3:0]       w_flags;
    logic [ENT_W-1:0] w_head;

    // Slots already claimed include the op still in flight through the logic units.
    assign w_credit    = r_count + OCC_W'(r_pend_v);
    assign w_in_ready  = !rst && (w_credit < OCC_W'(DEPTH));
    assign w_issue     = bus.in_valid && w_in_ready;
    assign w_capture   = r_pend_v;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Select the unit output for the pending opcode and derive status flags.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_pend_op)
            2'b00:   w_result = bus.xor_output;
            2'b01:   w_result = bus.xnor_output;
            default: w_err    = 1'b1;
        endcase
        w_flags = {w_err, ^w_result, w_result[WIDTH-1], (w_result == '0)};
    end

    // Control state: pending-op tracker, FIFO pointers/occupancy, pop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_v   <= 1'b0;
            r_pend_op  <= 2'b00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_op_count <= '0;
        end else begin
            r_pend_v <= w_issue;
            if (w_issue) begin
                r_pend_op <= bus.in_op;
            end
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop && (r_op_count != '1)) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    // FIFO storage is unreset; reads are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_capture && !rst) begin
            r_mem[r_wr_ptr] <= {w_flags, w_result};
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_valid ? w_head[WIDTH-1:0] : '0;
    assign bus.out_flags  = w_out_valid ? w_head[ENT_W-1:WIDTH] : 4'b0000;
    assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_alu_logic_collector.sv
// Randomized and directed bench for alu_logic_collector against a queue-based model.
module tb_alu_logic_collector;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;   // small so saturation is reached

    logic clk;
    logic rst;

    alu_logic_collector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_logic_collector #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state
    logic [19:0] m_q[$];
    bit          m_pend;
    logic [1:0]  m_pop;
    logic [15:0] m_pa;
    logic [15:0] m_pb;
    int unsigned m_cnt;

    logic [15:0] a_drv;
    logic [15:0] b_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] model_entry(input logic [1:0] op, input logic [15:0] a,
                                                input logic [15:0] b);
        logic [15:0] r;
        logic        err;
        err = (op > 2'd1);
        if (op == 2'd0)      r = a ^ b;
        else if (op == 2'd1) r = ~(a ^ b);
        else                 r = 16'h0000;
        return {err, 1'($countones(r) % 2), r[15], (r == 16'h0000), r};
    endfunction

    function automatic bit model_ready();
        return !rst && ((m_q.size() + int'(m_pend)) < DEPTH);
    endfunction

    task automatic check_outputs();
        logic [19:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 20'h0;
        check("in_ready",   32'(bus.in_ready),   32'(model_ready()));
        check("out_valid",  32'(bus.out_valid),  32'(m_q.size() != 0));
        check("out_result", 32'(bus.out_result), 32'(head[15:0]));
        check("out_flags",  32'(bus.out_flags),  32'(head[19:16]));
        check("op_count",   32'(bus.op_count),   m_cnt);
    endtask

    // One clock: drive at negedge, advance model past posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy, input logic r);
        bit rdy;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.out_ready = ordy;
        a_drv         = a;
        b_drv         = b;
        rst           = r;
        rdy           = model_ready();
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete();
            m_pend = 1'b0;
            m_cnt  = 0;
        end else begin
            if (m_q.size() != 0 && ordy) begin
                void'(m_q.pop_front());
                if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
            end
            if (m_pend) m_q.push_back(model_entry(m_pop, m_pa, m_pb));
            m_pend = v && rdy;
            if (m_pend) begin
                m_pop = op;
                m_pa  = a;
                m_pb  = b;
            end
        end
        // Logic units register a/b presented in the cycle just ended.
        bus.xor_output  = a_drv ^ b_drv;
        bus.xnor_output = ~(a_drv ^ b_drv);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_pend = 1'b0;
        m_pop = 2'b00;
        m_pa = '0;
        m_pb = '0;
        m_cnt = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.out_ready = 1'b0;
        bus.xor_output = '0;
        bus.xnor_output = '0;
        a_drv = '0;
        b_drv = '0;
        @(negedge clk);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);

        // Single XOR
        cycle(1'b1, 2'b00, 16'h00FF, 16'h0F0F, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        check("xor_result", 32'(bus.out_result), 32'h0FF0);
        check("xor_flags",  32'(bus.out_flags),  32'h0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        check("xor_count",  32'(bus.op_count),   32'd1);

        // XNOR then XOR of equal operands
        cycle(1'b1, 2'b01, 16'h1234, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("xnor_result", 32'(bus.out_result), 32'hFFFF);
        check("xnor_flags",  32'(bus.out_flags),  32'h2);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        check("xeq_flags",   32'(bus.out_flags),  32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        // Backpressure: fill, then drain
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 2'(i % 2), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        // Streaming with pointer wrap
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 2'(i % 2), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        // Illegal op then legal op
        cycle(1'b1, 2'b10, 16'hA5A5, 16'h1234, 1'b1, 1'b0);
        cycle(1'b1, 2'b00, 16'h8000, 16'h0001, 1'b1, 1'b0);
        check("ill_result", 32'(bus.out_result), 32'h0);
        check("ill_flags",  32'(bus.out_flags),  32'h9);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        check("post_ill_result", 32'(bus.out_result), 32'h8001);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        // Reset mid-op
        cycle(1'b1, 2'b01, 16'h00F0, 16'h0F00, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.op_count),  32'd0);
        check("rst_ready_after", 32'(bus.in_ready), 32'd1);
        cycle(1'b1, 2'b11, 16'h1111, 16'h2222, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        // Randomized phases with varying valid/ready pressure
        for (int ph = 0; ph < 6; ph++) begin
            int unsigned pv;
            int unsigned pr;
            pv = 30 + 15 * ph;
            pr = 95 - 15 * ph;
            for (int i = 0; i < 300; i++) begin
                cycle(1'($urandom_range(99) < pv), 2'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(99) < pr), 1'($urandom_range(199) == 0));
            end
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
